mlp_seq_core: RTL and testbench

Time-multiplexed two-layer quantised MLP classifier for printed-electronics inference. It is the sequential, parametrised successor of the fully-parallel combinational `top` classifier. One shared multiply-accumulate unit iterates over all neurons, so area drops in exchange for latency. The block sits between the sensor-sample front end and the class consumer and uses a valid/ready handshake on both sides.

---
 rtl/mlp_seq_pkg.sv | 43 ++++
 rtl/mlp_mac.sv | 74 +++++++
 rtl/mlp_seq_core.sv | 232 +++++++++++++++++++++++
 tb/tb_mlp_seq_core.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_seq_pkg.sv
// mlp_seq_pkg
// Shared definitions for the time-multiplexed MLP classifier:
//   - state_t        : sequencer state encoding
//   - w0_idx/w1_idx  : flat weight-vector index of w0[h][i] / w1[o][h]
//   - b0_pos/b1_pos  : bit offset of b0[h] / b1[o] in the flat bias vector
//   - lat            : accept-to-out_valid latency in clock edges
//   - cnt_w          : counter width for a loop of n iterations (min 1 bit)
package mlp_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_L0_MAC = 3'd1,
      S_L0_ACT = 3'd2,
      S_L1_MAC = 3'd3,
      S_L1_CMP = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   function automatic int w0_idx(input int n_in, input int h, input int i);
      return h * n_in + i;
   endfunction

   function automatic int w1_idx(input int n_in, input int n_hid, input int o, input int h);
      return n_in * n_hid + o * n_hid + h;
   endfunction

   function automatic int b0_pos(input int w_b0, input int h);
      return h * w_b0;
   endfunction

   function automatic int b1_pos(input int n_hid, input int w_b0, input int w_b1, input int o);
      return n_hid * w_b0 + o * w_b1;
   endfunction

   function automatic int lat(input int n_in, input int n_hid, input int n_out);
      return n_hid * (n_in + 1) + n_out * (n_hid + 1);
   endfunction

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mlp_mac.sv
// mlp_mac
// Shared multiply-accumulate datapath. Selects the layer operand
// (zero-extended input feature or hidden activation), sign-extends the
// weight and bias, multiplies modulo 2^ACC_W and either loads the bias
// or accumulates into the held accumulator.
// Optional build macro: MLP_FAULT_INJECT_EN adds a stuck-at hook on the
// accumulator write path.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   en               write the accumulator this cycle
//   first            start a new neuron: bias replaces the held accumulator
//   layer1           0: x/b0 operands (hidden layer), 1: hid/b1 (output layer)
//   x, hid           unsigned operands
//   w                signed weight
//   b0, b1           signed biases
//   fi_en/sel/val    fault-injection controls (macro builds only)
//   acc              accumulator value
module mlp_mac
   import mlp_seq_pkg::*;
#(
   parameter int WIDTH_A  = 4,
   parameter int WIDTH_W  = 8,
   parameter int WIDTH_B0 = 11,
   parameter int WIDTH_B1 = 14,
   parameter int WIDTH_H  = 8,
   parameter int ACC_W    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 first,
   input  logic                 layer1,
   input  logic [WIDTH_A-1:0]   x,
   input  logic [WIDTH_H-1:0]   hid,
   input  logic [WIDTH_W-1:0]   w,
   input  logic [WIDTH_B0-1:0]  b0,
   input  logic [WIDTH_B1-1:0]  b1,
`ifdef MLP_FAULT_INJECT_EN
   input  logic                 fi_en,
   input  logic [$clog2(ACC_W)-1:0] fi_sel,
   input  logic                 fi_val,
`endif
   output logic [ACC_W-1:0]     acc
);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] op_ext, w_ext, bias_ext, prod, wr_val;

   always_comb begin
      op_ext = '0;
      if (layer1) op_ext[WIDTH_H-1:0] = hid;
      else        op_ext[WIDTH_A-1:0] = x;

      w_ext    = ACC_W'($signed(w));
      bias_ext = layer1 ? ACC_W'($signed(b1)) : ACC_W'($signed(b0));

      // Low ACC_W bits of the product are identical for signed and unsigned
      // interpretation, so an unsigned multiply gives the wrapped result.
      prod   = op_ext * w_ext;
      wr_val = (first ? bias_ext : acc_q) + prod;
`ifdef MLP_FAULT_INJECT_EN
      if (fi_en) wr_val[fi_sel] = fi_val;
`endif
      acc_d = en ? wr_val : acc_q;
   end

   always_ff @(posedge clk) begin
      if (rst) acc_q <= '0;
      else     acc_q <= acc_d;
   end

   assign acc = acc_q;

endmodule

// File: rtl/mlp_seq_core.sv
// mlp_seq_core
// Sequential two-layer quantised MLP classifier. One shared MAC walks all
// hidden neurons (ReLU, shift, saturate into a hidden register file) and
// then all output neurons, tracking the running argmax.
// Optional build macro: MLP_FAULT_INJECT_EN adds fi_en/fi_sel/fi_val.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid, in_ready    input handshake; inp is captured on acceptance
//   inp                   N_IN unsigned features, feature i at [i*WIDTH_A +:]
//   weights, biases       flat parameter vectors, held stable while busy
//   out_valid, out_ready  result handshake
//   out                   argmax class index, held until the next result
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | in_ready=1, waiting for a sample
// L0_MAC   | hidden neuron h: bias load at i=0, accumulate x[i]*w0[h][i]
// L0_ACT   | hid[h] = sat(relu(acc) >>> SHIFT0), next h or output layer
// L1_MAC   | output neuron o: bias load at h=0, accumulate hid[h]*w1[o][h]
// L1_CMP   | strict-greater argmax update, next o or DONE
// DONE     | out_valid=1, wait for out_ready
module mlp_seq_core
   import mlp_seq_pkg::*;
#(
   parameter int N_IN     = 8,
   parameter int N_HID    = 3,
   parameter int N_OUT    = 3,
   parameter int WIDTH_A  = 4,
   parameter int WIDTH_W  = 8,
   parameter int WIDTH_B0 = 11,
   parameter int WIDTH_B1 = 14,
   parameter int WIDTH_H  = 8,
   parameter int SHIFT0   = 4,
   parameter int ACC_W    = 16,
   parameter int OUTWIDTH = $clog2(N_OUT)
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        in_valid,
   output logic                                        in_ready,
   input  logic [N_IN*WIDTH_A-1:0]                     inp,
   input  logic [(N_IN*N_HID+N_HID*N_OUT)*WIDTH_W-1:0] weights,
   input  logic [N_HID*WIDTH_B0+N_OUT*WIDTH_B1-1:0]    biases,
   output logic                                        out_valid,
   input  logic                                        out_ready,
`ifdef MLP_FAULT_INJECT_EN
   input  logic                                        fi_en,
   input  logic [$clog2(ACC_W)-1:0]                    fi_sel,
   input  logic                                        fi_val,
`endif
   output logic [OUTWIDTH-1:0]                         out
);

   localparam int IW   = cnt_w(N_IN);
   localparam int HW   = cnt_w(N_HID);
   localparam int OW   = cnt_w(N_OUT);
   localparam int HMAX = (1 << WIDTH_H) - 1;

   state_t                     state_q, state_d;
   logic [IW-1:0]              i_q, i_d;
   logic [HW-1:0]              h_q, h_d;
   logic [OW-1:0]              o_q, o_d;
   logic [N_IN*WIDTH_A-1:0]    inp_q, inp_d;
   logic [WIDTH_H-1:0]         hid_q [N_HID];
   logic [WIDTH_H-1:0]         hid_d [N_HID];
   logic [ACC_W-1:0]           best_q, best_d;
   logic [OW-1:0]              cls_q, cls_d;
   logic [OUTWIDTH-1:0]        out_q, out_d;

   logic                       mac_en, mac_first, mac_l1;
   logic [ACC_W-1:0]           acc;
   logic [WIDTH_A-1:0]         x_sel;
   logic [WIDTH_H-1:0]         hid_sel;
   logic [WIDTH_W-1:0]         w_sel;
   logic [WIDTH_B0-1:0]        b0_sel;
   logic [WIDTH_B1-1:0]        b1_sel;
   logic [ACC_W-1:0]           acc_shr;
   logic [WIDTH_H-1:0]         act;
   logic                       take_new;
   int                         w_k;

   // Operand selection for the shared MAC.
   always_comb begin
      mac_l1  = (state_q == S_L1_MAC);
      x_sel   = inp_q[int'(i_q)*WIDTH_A +: WIDTH_A];
      hid_sel = hid_q[h_q];
      w_k     = mac_l1 ? w1_idx(N_IN, N_HID, int'(o_q), int'(h_q))
                       : w0_idx(N_IN, int'(h_q), int'(i_q));
      w_sel   = weights[w_k*WIDTH_W +: WIDTH_W];
      b0_sel  = biases[b0_pos(WIDTH_B0, int'(h_q)) +: WIDTH_B0];
      b1_sel  = biases[b1_pos(N_HID, WIDTH_B0, WIDTH_B1, int'(o_q)) +: WIDTH_B1];
   end

   // ReLU, then shift (logical is fine once non-negative), then saturate.
   always_comb begin
      acc_shr = acc >> SHIFT0;
      if (acc[ACC_W-1])                 act = '0;
      else if (acc_shr > ACC_W'(HMAX))  act = '1;
      else                              act = acc_shr[WIDTH_H-1:0];
   end

   assign take_new = (o_q == '0) || ($signed(acc) > $signed(best_q));

   always_comb begin
      state_d   = state_q;
      i_d       = i_q;
      h_d       = h_q;
      o_d       = o_q;
      inp_d     = inp_q;
      hid_d     = hid_q;
      best_d    = best_q;
      cls_d     = cls_q;
      out_d     = out_q;
      mac_en    = 1'b0;
      mac_first = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               inp_d   = inp;
               i_d     = '0;
               h_d     = '0;
               state_d = S_L0_MAC;
            end
         end
         S_L0_MAC: begin
            mac_en    = 1'b1;
            mac_first = (i_q == '0);
            if (i_q == IW'(N_IN-1)) begin
               i_d     = '0;
               state_d = S_L0_ACT;
            end else begin
               i_d = i_q + 1'b1;
            end
         end
         S_L0_ACT: begin
            hid_d[h_q] = act;
            if (h_q == HW'(N_HID-1)) begin
               h_d     = '0;
               o_d     = '0;
               state_d = S_L1_MAC;
            end else begin
               h_d     = h_q + 1'b1;
               state_d = S_L0_MAC;
            end
         end
         S_L1_MAC: begin
            mac_en    = 1'b1;
            mac_first = (h_q == '0);
            if (h_q == HW'(N_HID-1)) begin
               h_d     = '0;
               state_d = S_L1_CMP;
            end else begin
               h_d = h_q + 1'b1;
            end
         end
         S_L1_CMP: begin
            if (take_new) begin
               best_d = acc;
               cls_d  = o_q;
            end
            if (o_q == OW'(N_OUT-1)) begin
               // out only changes here, so it stays put outside DONE entry.
               out_d   = OUTWIDTH'(take_new ? o_q : cls_q);
               state_d = S_DONE;
            end else begin
               o_d     = o_q + 1'b1;
               state_d = S_L1_MAC;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         i_q     <= '0;
         h_q     <= '0;
         o_q     <= '0;
         inp_q   <= '0;
         best_q  <= '0;
         cls_q   <= '0;
         out_q   <= '0;
         for (int k = 0; k < N_HID; k++) hid_q[k] <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         h_q     <= h_d;
         o_q     <= o_d;
         inp_q   <= inp_d;
         best_q  <= best_d;
         cls_q   <= cls_d;
         out_q   <= out_d;
         for (int k = 0; k < N_HID; k++) hid_q[k] <= hid_d[k];
      end
   end

   mlp_mac #(
      .WIDTH_A  (WIDTH_A),
      .WIDTH_W  (WIDTH_W),
      .WIDTH_B0 (WIDTH_B0),
      .WIDTH_B1 (WIDTH_B1),
      .WIDTH_H  (WIDTH_H),
      .ACC_W    (ACC_W)
   ) u_mac (
      .clk    (clk),
      .rst    (rst),
      .en     (mac_en),
      .first  (mac_first),
      .layer1 (mac_l1),
      .x      (x_sel),
      .hid    (hid_sel),
      .w      (w_sel),
      .b0     (b0_sel),
      .b1     (b1_sel),
`ifdef MLP_FAULT_INJECT_EN
      .fi_en  (fi_en),
      .fi_sel (fi_sel),
      .fi_val (fi_val),
`endif
      .acc    (acc)
   );

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign out       = out_q;

endmodule

// File: tb/tb_mlp_seq_core.sv
// tb_mlp_seq_core
// Table-driven bench for mlp_seq_core at default parameters, plus
// hand-written sequences for backpressure, busy input and mid-run reset.
module tb_mlp_seq_core;
   import mlp_seq_pkg::*;

   localparam int WB  = (8*3 + 3*3) * 8;
   localparam int BB  = 3*11 + 3*14;
   localparam int LAT = 39;

   typedef struct {
      logic [31:0]   inp;
      logic [WB-1:0] w;
      logic [BB-1:0] b;
      int            exp_out;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   inp;
   logic [WB-1:0] weights;
   logic [BB-1:0] biases;
   logic          out_valid;
   logic          out_ready;
   logic [1:0]    out;
`ifdef MLP_FAULT_INJECT_EN
   logic          fi_en  = 1'b0;
   logic [3:0]    fi_sel = 4'd15;
   logic          fi_val = 1'b1;
`endif

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   mlp_seq_core dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .inp       (inp),
      .weights   (weights),
      .biases    (biases),
      .out_valid (out_valid),
      .out_ready (out_ready),
`ifdef MLP_FAULT_INJECT_EN
      .fi_en     (fi_en),
      .fi_sel    (fi_sel),
      .fi_val    (fi_val),
`endif
      .out       (out)
   );

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic logic [WB-1:0] sw(input logic [WB-1:0] v, input int k, input int val);
      logic [31:0] t;
      t = val;
      v[k*8 +: 8] = t[7:0];
      return v;
   endfunction

   function automatic logic [BB-1:0] sb0(input logic [BB-1:0] v, input int h, input int val);
      logic [31:0] t;
      t = val;
      v[h*11 +: 11] = t[10:0];
      return v;
   endfunction

   function automatic logic [BB-1:0] sb1(input logic [BB-1:0] v, input int o, input int val);
      logic [31:0] t;
      t = val;
      v[33 + o*14 +: 14] = t[13:0];
      return v;
   endfunction

   // Waits (bounded) for out_valid; returns edges counted since the caller's
   // last edge.
   task automatic wait_done(output int cnt);
      cnt = 0;
      while (out_valid !== 1'b1 && cnt < 200) begin
         @(posedge clk); #1;
         cnt++;
      end
   endtask

   task automatic accept(input vec_t v);
      inp      = v.inp;
      weights  = v.w;
      biases   = v.b;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic release_result(input string name);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({name, " in_ready after handshake"}, int'(in_ready), 1);
      check({name, " out_valid after handshake"}, int'(out_valid), 0);
   endtask

   task automatic run_vec(input vec_t v, input string name);
      int cnt;
      check({name, " in_ready before"}, int'(in_ready), 1);
      accept(v);
      wait_done(cnt);
      check({name, " latency"}, cnt, LAT);
      check({name, " out"}, int'(out), v.exp_out);
      release_result(name);
   endtask

   initial begin
      vec_t          vecs[8];
      vec_t          vb;
      logic [WB-1:0] w;
      logic [BB-1:0] b;
      int            cnt;
      int            stable;

      // bias-only: b1={10,20,5}
      b = '0; b = sb1(b, 0, 10); b = sb1(b, 1, 20); b = sb1(b, 2, 5);
      vecs[0] = '{inp: 32'h1234_5678, w: '0, b: b, exp_out: 1};
      // tie resolves to lowest index
      b = '0; b = sb1(b, 0, 7); b = sb1(b, 1, 7); b = sb1(b, 2, 7);
      vecs[1] = '{inp: 32'hA5A5_0F0F, w: '0, b: b, exp_out: 0};
      // ReLU clamp: acc=-85 -> hid0=0, all scores 0 -> class 0
      w = '0; w = sw(w, 0, 1); w = sw(w, 30, 1);
      b = '0; b = sb0(b, 0, -100);
      vecs[2] = '{inp: 32'hFFFF_FFFF, w: w, b: b, exp_out: 0};
      // acc=115 -> hid0=7 -> score2=7
      b = '0; b = sb0(b, 0, 100);
      vecs[3] = '{inp: 32'hFFFF_FFFF, w: w, b: b, exp_out: 2};
      // saturation: 15*127*8=15240 >>4 = 952 -> 255, only w1[1][0]=1
      w = '0;
      for (int k = 0; k < 24; k++) w = sw(w, k, 127);
      w = sw(w, 27, 1);
      vecs[4] = '{inp: 32'hFFFF_FFFF, w: w, b: '0, exp_out: 1};
      // all-negative scores, signed compare
      b = '0; b = sb1(b, 0, -5); b = sb1(b, 1, -3); b = sb1(b, 2, -9);
      vecs[5] = '{inp: 32'h0, w: '0, b: b, exp_out: 1};
      // later tie does not displace first maximum
      b = '0; b = sb1(b, 0, -1); b = sb1(b, 1, 5); b = sb1(b, 2, 5);
      vecs[6] = '{inp: 32'h1111_1111, w: '0, b: b, exp_out: 1};
      // x=1..8, w0[1][*]=-2, b0[1]=300 -> 228>>4=14; scores 36, 42, 38
      w = '0;
      for (int k = 0; k < 8; k++) w = sw(w, 8 + k, -2);
      w = sw(w, 25, -1); w = sw(w, 28, 3); w = sw(w, 31, 2);
      b = '0; b = sb0(b, 1, 300); b = sb1(b, 0, 50); b = sb1(b, 2, 10);
      vecs[7] = '{inp: 32'h8765_4321, w: w, b: b, exp_out: 1};

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      inp       = '0;
      weights   = '0;
      biases    = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset in_ready", int'(in_ready), 1);
      check("reset out_valid", int'(out_valid), 0);
      check("reset out", int'(out), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int n = 0; n < 8; n++) run_vec(vecs[n], $sformatf("vec%0d", n));

      // Backpressure: DONE holds with out stable.
      accept(vecs[0]);
      wait_done(cnt);
      check("bp latency", cnt, LAT);
      stable = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (out_valid === 1'b1 && out === 2'd1 && in_ready === 1'b0) stable++;
      end
      check("bp stable cycles", stable, 10);
      release_result("bp");

      // Busy input: in_valid held with a different sample after acceptance.
      // w0[0][1]=16 makes the result depend on feature 1, consumed on the
      // second MAC edge, so a re-capture would change the class.
      w = '0; w = sw(w, 1, 16); w = sw(w, 30, 1);
      vb = '{inp: 32'hFFFF_FFFF, w: w, b: '0, exp_out: 2};
      accept(vb);
      inp      = '0;
      in_valid = 1'b1;
      stable   = 0;
      for (int c = 0; c < 3; c++) begin
         if (in_ready === 1'b0) stable++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      wait_done(cnt);
      check("busy in_ready low", stable, 3);
      check("busy latency", cnt + 3, LAT);
      check("busy out", int'(out), 2);
      release_result("busy");

      // Reset in the middle of L0_MAC discards the run and clears out.
      accept(vecs[0]);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst in_ready", int'(in_ready), 1);
      check("midrst out_valid", int'(out_valid), 0);
      check("midrst out", int'(out), 0);
      rst = 1'b0;
      @(posedge clk); #1;
      run_vec(vecs[3], "after_rst");

`ifdef MLP_FAULT_INJECT_EN
      // Bit 15 forced on every accumulator write: all hid clamp to 0 and
      // scores become 10|0x8000, 20|0x8000, 5|0x8000 -> largest is class 1.
      fi_en = 1'b1;
      vb = vecs[0];
      vb.exp_out = 1;
      run_vec(vb, "fault");
      fi_en = 1'b0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
